// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage for the 16-bit processor core. Holds a programmable
//   instruction memory and a program counter, and drives one instruction
//   word per cycle. HALT is handled here. JMP is handled here when the
//   design is compiled with FETCH_JUMP_EN defined. Without that macro,
//   opcode 0x8 is passed through as an ordinary word.
//   Whenever no real word is available, the output is NOP (16'h0000).
//
// Parameters
//   ADDR_W      PC / memory address width (1..12), memory depth 2**ADDR_W
//   DATA_W      instruction width (16 for the current ISA)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   prog_we     program write strobe (honoured in IDLE and HALT only)
//   prog_addr   program write address
//   prog_data   program write data
//   start       begin fetching at address 0 (from IDLE or HALT)
//   stall       hold all fetch state and outputs
//   instruction registered word to the core
//   instr_valid instruction is a real program word
//   pc          address of the word currently on instruction
//   halted      unit is in HALT
//   busy        unit is in FETCH
module instr_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              start,
    input  logic              stall,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              busy
);

    localparam logic [3:0] OP_HALT = 4'hF;
`ifdef FETCH_JUMP_EN
    localparam logic [3:0] OP_JMP  = 4'h8;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] fp, fp_n;
    logic [DATA_W-1:0] instr_n;
    logic              valid_n;
    logic [ADDR_W-1:0] pc_n;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] w;
    logic [3:0]        opcode;

    assign w      = mem[fp];
    assign opcode = w[DATA_W-1:DATA_W-4];

    // Program memory: not cleared by reset; writes locked out while fetching.
    always_ff @(posedge clk) begin
        if (prog_we && state != S_FETCH)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fp          <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            fp          <= fp_n;
            instruction <= instr_n;
            instr_valid <= valid_n;
            pc          <= pc_n;
            busy        <= (state_n == S_FETCH);
            halted      <= (state_n == S_HALT);
        end
    end

    always_comb begin
        state_n = state;
        fp_n    = fp;
        instr_n = instruction;
        valid_n = instr_valid;
        pc_n    = pc;
        case (state)
            S_IDLE, S_HALT: begin
                instr_n = '0;
                valid_n = 1'b0;
                if (start) begin
                    state_n = S_FETCH;
                    fp_n    = '0;
                end
            end
            S_FETCH: begin
                if (!stall) begin
                    pc_n = fp;
                    if (opcode == OP_HALT) begin
                        instr_n = '0;
                        valid_n = 1'b0;
                        state_n = S_HALT;
                    end
`ifdef FETCH_JUMP_EN
                    else if (opcode == OP_JMP) begin
                        // The JMP word is consumed here; the core sees a bubble.
                        instr_n = '0;
                        valid_n = 1'b0;
                        fp_n    = w[ADDR_W-1:0];
                    end
`endif
                    else begin
                        instr_n = w;
                        valid_n = 1'b1;
                        fp_n    = fp + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                instr_n = '0;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance, ADDR_W = 8
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        halted;
    logic        busy;

    // Wrap-around instance, ADDR_W = 2
    logic        wprog_we = 1'b0;
    logic [1:0]  wprog_addr = '0;
    logic [15:0] wprog_data = '0;
    logic        wstart = 1'b0;
    logic        wstall = 1'b0;
    logic [15:0] winstruction;
    logic        winstr_valid;
    logic [1:0]  wpc;
    logic        whalted;
    logic        wbusy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .stall(stall),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
        .halted(halted), .busy(busy)
    );

    instr_fetch_unit #(.ADDR_W(2), .DATA_W(16)) dut_w (
        .clk(clk), .rst(rst),
        .prog_we(wprog_we), .prog_addr(wprog_addr), .prog_data(wprog_data),
        .start(wstart), .stall(wstall),
        .instruction(winstruction), .instr_valid(winstr_valid), .pc(wpc),
        .halted(whalted), .busy(wbusy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic wload(input logic [1:0] a, input logic [15:0] d);
        wprog_we = 1'b1; wprog_addr = a; wprog_data = d;
        step();
        wprog_we = 1'b0;
    endtask

    // Pulse start for one edge; leaves the unit in FETCH with no word yet.
    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] i, input logic v,
                              input logic [7:0] p, input logic h, input logic b);
        check({tag, ".instr"},  32'(instruction), 32'(i));
        check({tag, ".valid"},  32'(instr_valid), 32'(v));
        check({tag, ".pc"},     32'(pc),          32'(p));
        check({tag, ".halted"}, 32'(halted),      32'(h));
        check({tag, ".busy"},   32'(busy),        32'(b));
    endtask

    initial begin
        // Reset state
        #12;
        expect_out("reset", 16'h0000, 1'b0, 8'd0, 1'b0, 1'b0);
        check("reset.w_busy", 32'(wbusy), 32'd0);
        rst = 1'b0;
        step();
        expect_out("idle", 16'h0000, 1'b0, 8'd0, 1'b0, 1'b0);

        // Basic program: ADD, SUB, HALT
        load(8'd0, 16'h1050);
        load(8'd1, 16'h2458);
        load(8'd2, 16'hF000);
        kick();
        expect_out("basic.n", 16'h0000, 1'b0, 8'd0, 1'b0, 1'b1);
        step();
        expect_out("basic.w0", 16'h1050, 1'b1, 8'd0, 1'b0, 1'b1);
        step();
        expect_out("basic.w1", 16'h2458, 1'b1, 8'd1, 1'b0, 1'b1);
        step();
        expect_out("basic.halt", 16'h0000, 1'b0, 8'd2, 1'b1, 1'b0);
        step();
        expect_out("basic.halt2", 16'h0000, 1'b0, 8'd2, 1'b1, 1'b0);

        // Stall for 3 cycles while 0x1050 is presented
        kick();
        step();
        expect_out("stall.w0", 16'h1050, 1'b1, 8'd0, 1'b0, 1'b1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out($sformatf("stall.hold%0d", k), 16'h1050, 1'b1, 8'd0, 1'b0, 1'b1);
        end
        stall = 1'b0;
        step();
        expect_out("stall.w1", 16'h2458, 1'b1, 8'd1, 1'b0, 1'b1);
        step();
        expect_out("stall.halt", 16'h0000, 1'b0, 8'd2, 1'b1, 1'b0);

        // Jump program
        load(8'd1, 16'h8005);
        load(8'd5, 16'h3600);
        load(8'd6, 16'hF000);
        kick();
        step();
        expect_out("jmp.w0", 16'h1050, 1'b1, 8'd0, 1'b0, 1'b1);
        step();
`ifdef FETCH_JUMP_EN
        expect_out("jmp.bubble", 16'h0000, 1'b0, 8'd1, 1'b0, 1'b1);
        step();
        expect_out("jmp.target", 16'h3600, 1'b1, 8'd5, 1'b0, 1'b1);
        step();
        expect_out("jmp.halt", 16'h0000, 1'b0, 8'd6, 1'b1, 1'b0);
`else
        expect_out("nojmp.w1", 16'h8005, 1'b1, 8'd1, 1'b0, 1'b1);
        step();
        expect_out("nojmp.halt", 16'h0000, 1'b0, 8'd2, 1'b1, 1'b0);
`endif
        load(8'd1, 16'h2458);

        // Write during FETCH ignored, write during HALT honoured
        kick();
        prog_we = 1'b1; prog_addr = 8'd1; prog_data = 16'h4000;
        step();
        prog_we = 1'b0;
        expect_out("wrf.w0", 16'h1050, 1'b1, 8'd0, 1'b0, 1'b1);
        step();
        expect_out("wrf.w1", 16'h2458, 1'b1, 8'd1, 1'b0, 1'b1);
        step();
        expect_out("wrf.halt", 16'h0000, 1'b0, 8'd2, 1'b1, 1'b0);
        load(8'd1, 16'h4000);
        kick();
        step();
        expect_out("wrh.w0", 16'h1050, 1'b1, 8'd0, 1'b0, 1'b1);
        step();
        expect_out("wrh.w1", 16'h4000, 1'b1, 8'd1, 1'b0, 1'b1);
        step();
        expect_out("wrh.halt", 16'h0000, 1'b0, 8'd2, 1'b1, 1'b0);

        // Simultaneous start and write to address 0 in HALT
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h5008; start = 1'b1;
        step();
        prog_we = 1'b0; start = 1'b0;
        step();
        expect_out("sw.w0", 16'h5008, 1'b1, 8'd0, 1'b0, 1'b1);
        step();
        expect_out("sw.w1", 16'h4000, 1'b1, 8'd1, 1'b0, 1'b1);

        // Asynchronous reset mid-FETCH, then restart re-fetches retained memory
        #2;
        rst = 1'b1;
        #1;
        expect_out("arst", 16'h0000, 1'b0, 8'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step();
        expect_out("arst.idle", 16'h0000, 1'b0, 8'd0, 1'b0, 1'b0);
        kick();
        step();
        expect_out("arst.w0", 16'h5008, 1'b1, 8'd0, 1'b0, 1'b1);

        // Wrap-around on the ADDR_W = 2 instance
        wload(2'd0, 16'h1050);
        wload(2'd1, 16'h2458);
        wload(2'd2, 16'h1050);
        wload(2'd3, 16'h2458);
        wstart = 1'b1;
        step();
        wstart = 1'b0;
        for (int k = 0; k < 6; k++) begin
            // start while fetching must not restart at 0
            if (k == 3) wstart = 1'b1;
            step();
            wstart = 1'b0;
            check($sformatf("wrap.pc%0d", k),    32'(wpc),          32'(k % 4));
            check($sformatf("wrap.valid%0d", k), 32'(winstr_valid), 32'd1);
            check($sformatf("wrap.instr%0d", k), 32'(winstruction),
                  (k % 2 == 0) ? 32'h1050 : 32'h2458);
        end
        check("wrap.busy", 32'(wbusy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream fetch stage for the 16-bit `processor` core: holds a programmable instruction memory and a program counter, and drives the core's `instruction` input one word per cycle. Handles `HALT` itself, and handles `JMP` when compiled in. Presents NOP (`16'h0000`) whenever no valid instruction is available, because the core has no valid input and treats opcode 0 as a no-op. Program loading happens through a write port while the unit is idle or halted.

## Interface
- `ADDR_W`, default 8: PC and memory address width; memory depth = 2**`ADDR_W`; legal range 1..12.
- `DATA_W`, default 16: instruction width; fixed at 16 for the current ISA.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `prog_we`  in  1  memory write strobe.
- `prog_addr`  in  `ADDR_W`  write address.
- `prog_data`  in  16  write data.
- `start`  in  1  begin fetching at address 0.
- `stall`  in  1  hold all fetch state and outputs.
- `instruction`  out  16  registered word to the core.
- `instr_valid`  out  1  `instruction` is a real program word.
- `pc`  out  `ADDR_W`  address of the word currently on `instruction`.
- `halted`  out  1  unit is in the HALT state.
- `busy`  out  1  unit is in the FETCH state.

## Operation
- Instruction field layout: opcode `[15:12]`, rs1 `[11:9]`, rs2 `[8:6]`, rd `[5:3]`, `[2:0]` unused.
  - Opcodes `0x1`–`0x7` are core operations and pass through unchanged.
  - `0x0` is NOP.
  - `0xF` is HALT.
  - `0x8` is JMP, with target = `instr[ADDR_W-1:0]`.
- Memory:
  - 2**`ADDR_W` x 16, combinational read, synchronous write.
  - Contents are not cleared by `rst`.
- Internal fetch pointer `fp` (`ADDR_W` bits) is separate from `pc`.
- States: IDLE, FETCH, HALT.
- IDLE:
  - Outputs are NOP, `instr_valid`=0.
  - `prog_we` writes `mem[prog_addr]`.
  - `start`=1 moves to FETCH with `fp`=0.
- FETCH, each edge with `stall`=0; let `w` = `mem[fp]`:
  - Ordinary word (opcode not `0x8`/`0xF`): `instruction`←`w`, `instr_valid`←1, `pc`←`fp`, `fp`←`fp`+1.
  - JMP: `instruction`←0, `instr_valid`←0, `pc`←`fp`, `fp`←target. The JMP word never reaches the core.
  - HALT: `instruction`←0, `instr_valid`←0, `pc`←`fp`, go to HALT.
  - `prog_we` is ignored while in FETCH.
- `stall`=1 in FETCH: `instruction`, `instr_valid`, `pc`, `fp` and state all hold.
- HALT:
  - Outputs are NOP, `instr_valid`=0, `pc` holds.
  - `prog_we` is honoured.
  - `start` restarts FETCH at `fp`=0.
- `start` while in FETCH is ignored.
- Wrap-around: `fp` = 2**`ADDR_W`-1 increments to 0 with no flag raised.
- Simultaneous `start` and `prog_we` in IDLE/HALT: the write completes and fetch begins at 0. If `prog_addr`=0, the newly written word is the one fetched at edge N+1.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, `fp`=0.
  - `instruction`=`16'h0000`, `instr_valid`=0, `pc`=0, `halted`=0, `busy`=0.
- Reset mid-FETCH aborts the fetch immediately; memory is retained.
- Latency:
  - `start` sampled at edge N → FETCH.
  - `mem[0]` appears on `instruction` after edge N+1.
  - One word per cycle thereafter.
- JMP costs one NOP bubble cycle; the target word appears on the edge following the bubble.
- HALT:
  - The NOP is presented after the edge that fetched HALT.
  - `halted`=1 and `busy`=0 from that same edge.
- `stall` is sampled at each edge. Outputs are registered, so a stall freezes the value present before that edge.
- `busy` = state==FETCH; `halted` = state==HALT; both registered.

## Configuration
- `FETCH_JUMP_EN` defined: opcode `0x8` is executed as JMP, as described above.
- `FETCH_JUMP_EN` undefined:
  - Opcode `0x8` is an ordinary word: passed to the core with `instr_valid`=1, `fp`+1.
  - No jump logic is synthesized.

## Test plan
- Load `mem[0]`=`0x1050` (ADD), `mem[1]`=`0x2458` (SUB), `mem[2]`=`0xF000`, then pulse `start` → consecutive cycles show:
  - `0x1050`/`pc`0/`valid`1
  - `0x2458`/`pc`1/`valid`1
  - `0x0000`/`pc`2/`valid`0, `halted`=1
- Same program, `stall`=1 for 3 cycles while `0x1050` is presented → `0x1050`, `pc`=0 held for 3 cycles, then `0x2458`.
- With `FETCH_JUMP_EN`: `mem[0]`=`0x1050`, `mem[1]`=`0x8005`, `mem[5]`=`0x3600`, `mem[6]`=`0xF000` → sequence `0x1050`, NOP bubble (`pc`1, `valid`0), `0x3600` (`pc`5), halt. Without the macro, `0x8005` is output with `valid`=1 and `pc`=1.
- Wrap: `ADDR_W`=2, `mem`={`0x1050`,`0x2458`,`0x1050`,`0x2458`} → `pc` sequence 0,1,2,3,0,1, valid throughout.
- Assert `rst` asynchronously mid-FETCH → outputs go to 0 and `busy`=0 before the next edge. Then `start` again → `mem[0]` is unchanged and re-fetched.
- `prog_we` to address 1 (value `0x4000`) during FETCH → ignored; the second fetched word is still the original. The same write in HALT takes effect, and a restart fetches `0x4000`.
